// File: rtl/simpletim_alarm.sv
// Programmable down-counting alarm timer on the Z80 I/O bus: 16-bit reload, 8-bit prescaler,
// one-shot or periodic, one-cycle expiry tick and level active-low interrupt.
//   state | meaning
//   IDLE  | counter stopped, CTRL.EN reads 0
//   RUN   | prescaler/counter decrementing, CTRL.EN reads 1
module simpletim_alarm #(
    parameter logic [15:0] RELOAD_RST = 16'h0000,
    parameter logic [7:0]  PRESC_RST  = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [2:0] addr,
    output logic       irq_n,
    output logic       tick
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] reload_q, reload_d;
    logic [7:0]  presc_q, presc_d;
    logic        periodic_q, periodic_d;
    logic        ie_q, ie_d;
    logic        flag_q, flag_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  presc_cnt_q, presc_cnt_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        tick_q, tick_d;
    logic        irq_n_q, irq_n_d;
    logic        wr_sel_q, rd_sel_q;

    logic read_sel, write_sel, wr_edge, rd_edge, ctrl_wr, expire;

    always_comb begin
        read_sel    = !cs_n && !rd_n && wr_n;
        write_sel   = !cs_n && rd_n && !wr_n;
        wr_edge     = write_sel && !wr_sel_q;
        rd_edge     = read_sel && !rd_sel_q;
        ctrl_wr     = wr_edge && (addr == 3'd3);
        expire      = 1'b0;

        state_d     = state_q;
        reload_d    = reload_q;
        presc_d     = presc_q;
        periodic_d  = periodic_q;
        ie_d        = ie_q;
        flag_d      = flag_q;
        cnt_d       = cnt_q;
        presc_cnt_d = presc_cnt_q;
        shadow_d    = shadow_q;
        tick_d      = 1'b0;

        if (wr_edge) begin
            case (addr)
                3'd0: reload_d[7:0]  = data_in;
                3'd1: reload_d[15:8] = data_in;
                3'd2: presc_d        = data_in;
                3'd3: begin
                    periodic_d = data_in[1];
                    ie_d       = data_in[2];
                end
                3'd4: if (data_in[0]) flag_d = 1'b0;
                default: ;
            endcase
        end

        // A CTRL write pre-empts any expiry that would have happened this cycle.
        if (ctrl_wr) begin
            if (data_in[0]) begin
                cnt_d       = reload_q;
                presc_cnt_d = presc_q;
                state_d     = RUN;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == RUN) begin
            if (presc_cnt_q != 8'd0) begin
                presc_cnt_d = presc_cnt_q - 8'd1;
            end else if (cnt_q != 16'd0) begin
                presc_cnt_d = presc_q;
                cnt_d       = cnt_q - 16'd1;
            end else begin
                expire = 1'b1;
                tick_d = 1'b1;
                flag_d = 1'b1;
                if (periodic_q) begin
                    cnt_d       = reload_q;
                    presc_cnt_d = presc_q;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        if (rd_edge && (addr == 3'd5)) shadow_d = cnt_q[15:8];

        irq_n_d = !(flag_d && ie_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            reload_q    <= RELOAD_RST;
            presc_q     <= PRESC_RST;
            periodic_q  <= 1'b0;
            ie_q        <= 1'b0;
            flag_q      <= 1'b0;
            cnt_q       <= 16'd0;
            presc_cnt_q <= 8'd0;
            shadow_q    <= 8'd0;
            tick_q      <= 1'b0;
            irq_n_q     <= 1'b1;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            reload_q    <= reload_d;
            presc_q     <= presc_d;
            periodic_q  <= periodic_d;
            ie_q        <= ie_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
            presc_cnt_q <= presc_cnt_d;
            shadow_q    <= shadow_d;
            tick_q      <= tick_d;
            irq_n_q     <= irq_n_d;
            wr_sel_q    <= write_sel;
            rd_sel_q    <= read_sel;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (read_sel) begin
            case (addr)
                3'd0: data_out = reload_q[7:0];
                3'd1: data_out = reload_q[15:8];
                3'd2: data_out = presc_q;
                3'd3: data_out = {5'b0, ie_q, periodic_q, state_q == RUN};
                3'd4: data_out = {6'b0, state_q == RUN, flag_q};
                3'd5: data_out = cnt_q[7:0];
                3'd6: data_out = shadow_q;
                default: data_out = 8'h00;
            endcase
        end
    end

    assign tick  = tick_q;
    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_simpletim_alarm.sv
// Self-checking bench for simpletim_alarm: expiry times predicted as (RELOAD+1)*(PRESC+1)
// multiples of the CTRL write edge, register contents predicted from the register map.
module tb_simpletim_alarm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic       cs_n, rd_n, wr_n;
    logic [2:0] addr;
    logic       irq_n, tick;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int tick_log[$];

    always #5 clk = ~clk;

    simpletim_alarm dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_out (data_out),
        .data_in  (data_in),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .addr     (addr),
        .irq_n    (irq_n),
        .tick     (tick)
    );

    // cyc read at a negedge is the index of the posedge just before it
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tick === 1'b1) tick_log.push_back(cyc);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All bus tasks are entered at a negedge; the access edge is the next posedge.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d, output int e);
        addr = a; data_in = d; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        e = cyc;
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_write_held(input logic [2:0] a, input logic [7:0] d, input int n, output int e);
        addr = a; data_in = d; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        e = cyc;
        repeat (n - 1) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        addr = a; cs_n = 1'b0; rd_n = 1'b0;
        #1 d = data_out;
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic goto_edge(input int t);
        while (cyc < t - 1) @(negedge clk);
    endtask

    task automatic program_timer(input logic [15:0] r, input logic [7:0] p);
        int e;
        bus_write(3'd0, r[7:0], e);
        bus_write(3'd1, r[15:8], e);
        bus_write(3'd2, p, e);
    endtask

    task automatic stop_and_clear();
        int e;
        bus_write(3'd3, 8'h00, e);
        bus_write(3'd4, 8'h01, e);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b expected 0", tick); end
        tests_run++;
        if (irq_n !== 1'b1) begin tests_failed++; $display("FAIL reset_irq_n: got %b expected 1", irq_n); end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL idle_data_out: got %02h expected 00", data_out); end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d);
            tests_run++;
            if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_read addr%0d: got %02h expected 00", a, d); end
        end
    endtask

    task automatic test_oneshot();
        int e0, e;
        logic [7:0] d;
        program_timer(16'd3, 8'd1);
        tick_log.delete();
        bus_write(3'd3, 8'h05, e0);
        goto_edge(e0 + 20);
        tests_run++;
        if (tick_log.size() != 1 || tick_log[0] != e0 + 8) begin
            tests_failed++;
            $display("FAIL oneshot_tick: got %0d ticks first at +%0d expected 1 tick at +8",
                     tick_log.size(), tick_log.size() > 0 ? tick_log[0] - e0 : -1);
        end
        bus_read(3'd4, d);
        tests_run++;
        if (d !== 8'h01) begin tests_failed++; $display("FAIL oneshot_status: got %02h expected 01", d); end
        tests_run++;
        if (irq_n !== 1'b0) begin tests_failed++; $display("FAIL oneshot_irq_n: got %b expected 0", irq_n); end
        bus_write(3'd4, 8'h01, e);
        tests_run++;
        if (irq_n !== 1'b1) begin tests_failed++; $display("FAIL w1c_irq_n: got %b expected 1", irq_n); end
        bus_read(3'd4, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL w1c_status: got %02h expected 00", d); end
    endtask

    task automatic test_periodic();
        int e0, ew, n_exp;
        logic [7:0] d, cnt_exp;
        program_timer(16'd2, 8'd0);
        tick_log.delete();
        bus_write(3'd3, 8'h03, e0);
        goto_edge(e0 + 31);
        bus_read(3'd4, d);
        tests_run++;
        if (d !== 8'h03) begin tests_failed++; $display("FAIL periodic_status: got %02h expected 03", d); end
        bus_write(3'd3, 8'h00, ew);
        n_exp = (ew - 1 - e0) / 3;
        cnt_exp = 8'(2 - ((ew - 1 - e0) % 3));
        repeat (10) @(negedge clk);
        tests_run++;
        if (tick_log.size() != n_exp) begin
            tests_failed++; $display("FAIL periodic_count: got %0d ticks expected %0d", tick_log.size(), n_exp);
        end
        for (int k = 0; k < 10 && k < tick_log.size(); k++) begin
            tests_run++;
            if (tick_log[k] != e0 + 3 * (k + 1)) begin
                tests_failed++; $display("FAIL periodic_tick%0d: got +%0d expected +%0d", k, tick_log[k] - e0, 3 * (k + 1));
            end
        end
        bus_read(3'd5, d);
        tests_run++;
        if (d !== cnt_exp) begin tests_failed++; $display("FAIL frozen_cnt_a: got %02h expected %02h", d, cnt_exp); end
        repeat (5) @(negedge clk);
        bus_read(3'd5, d);
        tests_run++;
        if (d !== cnt_exp) begin tests_failed++; $display("FAIL frozen_cnt_b: got %02h expected %02h", d, cnt_exp); end
        stop_and_clear();
    endtask

    task automatic test_min_period();
        int e0, ew;
        logic [7:0] d;
        program_timer(16'd0, 8'd0);
        tick_log.delete();
        bus_write(3'd3, 8'h03, e0);
        goto_edge(e0 + 12);
        bus_write(3'd4, 8'h01, ew);
        bus_read(3'd4, d);
        tests_run++;
        if (d !== 8'h03) begin tests_failed++; $display("FAIL minper_w1c_status: got %02h expected 03", d); end
        bus_write(3'd3, 8'h00, ew);
        tests_run++;
        if (tick_log.size() != ew - 1 - e0) begin
            tests_failed++; $display("FAIL minper_count: got %0d ticks expected %0d", tick_log.size(), ew - 1 - e0);
        end
        for (int k = 0; k < tick_log.size(); k++) begin
            tests_run++;
            if (tick_log[k] != e0 + k + 1) begin
                tests_failed++; $display("FAIL minper_tick%0d: got +%0d expected +%0d", k, tick_log[k] - e0, k + 1);
            end
        end
        stop_and_clear();
    endtask

    task automatic test_w1c_race();
        int e0, e;
        logic [7:0] d;
        program_timer(16'd2, 8'd0);
        bus_write(3'd4, 8'h01, e);
        bus_write(3'd3, 8'h03, e0);
        goto_edge(e0 + 3);
        bus_write(3'd4, 8'h01, e);
        bus_write(3'd3, 8'h00, e);
        bus_read(3'd4, d);
        tests_run++;
        if (d !== 8'h01) begin tests_failed++; $display("FAIL w1c_race_status: got %02h expected 01", d); end
        stop_and_clear();
    endtask

    task automatic test_ctrl_race();
        int e0, e1;
        logic [7:0] d;
        program_timer(16'd1, 8'd1);
        tick_log.delete();
        bus_write(3'd3, 8'h05, e0);
        goto_edge(e0 + 4);
        bus_write(3'd3, 8'h05, e1);
        bus_read(3'd4, d);
        tests_run++;
        if (d !== 8'h02) begin tests_failed++; $display("FAIL ctrl_race_status: got %02h expected 02", d); end
        goto_edge(e1 + 6);
        tests_run++;
        if (tick_log.size() != 1 || tick_log[0] != e1 + 4) begin
            tests_failed++;
            $display("FAIL ctrl_race_tick: got %0d ticks first at +%0d expected 1 tick at +4 after rewrite",
                     tick_log.size(), tick_log.size() > 0 ? tick_log[0] - e1 : -1);
        end
        stop_and_clear();
    endtask

    task automatic test_atomic();
        int e0, k;
        logic [7:0] d, lo_exp;
        program_timer(16'h0100, 8'hFF);
        bus_write(3'd3, 8'h01, e0);
        bus_read(3'd5, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL atomic_lo: got %02h expected 00", d); end
        goto_edge(e0 + 300);
        bus_read(3'd6, d);
        tests_run++;
        if (d !== 8'h01) begin tests_failed++; $display("FAIL atomic_shadow: got %02h expected 01", d); end
        k = cyc - e0;
        lo_exp = 8'((256 - k / 256) & 255);
        bus_read(3'd5, d);
        tests_run++;
        if (d !== lo_exp) begin tests_failed++; $display("FAIL live_lo: got %02h expected %02h", d, lo_exp); end
        bus_read(3'd6, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL relatched_shadow: got %02h expected 00", d); end
        stop_and_clear();
    endtask

    task automatic test_held_strobe();
        int e0, e;
        logic [7:0] d;
        program_timer(16'd5, 8'd0);
        tick_log.delete();
        bus_write_held(3'd3, 8'h01, 4, e0);
        goto_edge(e0 + 10);
        tests_run++;
        if (tick_log.size() != 1 || tick_log[0] != e0 + 6) begin
            tests_failed++;
            $display("FAIL held_strobe_tick: got %0d ticks first at +%0d expected 1 tick at +6",
                     tick_log.size(), tick_log.size() > 0 ? tick_log[0] - e0 : -1);
        end
        program_timer(16'd3, 8'd0);
        bus_write(3'd3, 8'h07, e);
        repeat (2) @(negedge clk);
        tick_log.delete();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (tick !== 1'b0) begin tests_failed++; $display("FAIL midreset_tick: got %b expected 0", tick); end
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        tests_run++;
        if (tick_log.size() != 0) begin tests_failed++; $display("FAIL midreset_ticks: got %0d expected 0", tick_log.size()); end
        tests_run++;
        if (irq_n !== 1'b1) begin tests_failed++; $display("FAIL midreset_irq_n: got %b expected 1", irq_n); end
        bus_read(3'd4, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL midreset_status: got %02h expected 00", d); end
        bus_read(3'd0, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL midreset_reload: got %02h expected 00", d); end
    endtask

    task automatic test_random();
        int e0, e, per, w, k;
        int exp_q[$];
        logic [15:0] r;
        logic [7:0] p, d, st_exp, ctrl_exp;
        logic periodic, ie;
        for (int it = 0; it < 6; it++) begin
            r = 16'($urandom_range(0, 20));
            p = 8'($urandom_range(0, 5));
            periodic = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            per = (int'(r) + 1) * (int'(p) + 1);
            w = 3 * per + 4;
            program_timer(r, p);
            bus_write(3'd4, 8'h01, e);
            tick_log.delete();
            bus_write(3'd3, {5'b0, ie, periodic, 1'b1}, e0);
            goto_edge(e0 + w + 1);
            exp_q.delete();
            k = 1;
            while (k * per <= w && (periodic || k == 1)) begin
                exp_q.push_back(e0 + k * per);
                k++;
            end
            tests_run++;
            if (tick_log.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_count (R=%0d P=%0d per=%b): got %0d ticks expected %0d",
                         it, r, p, periodic, tick_log.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    tests_run++;
                    if (tick_log[j] != exp_q[j]) begin
                        tests_failed++;
                        $display("FAIL rand%0d_tick%0d: got +%0d expected +%0d", it, j, tick_log[j] - e0, exp_q[j] - e0);
                    end
                end
            end
            tests_run++;
            if (irq_n !== !ie) begin tests_failed++; $display("FAIL rand%0d_irq_n: got %b expected %b", it, irq_n, !ie); end
            st_exp = {6'b0, periodic, 1'b1};
            bus_read(3'd4, d);
            tests_run++;
            if (d !== st_exp) begin tests_failed++; $display("FAIL rand%0d_status: got %02h expected %02h", it, d, st_exp); end
            ctrl_exp = {5'b0, ie, periodic, periodic};
            bus_read(3'd3, d);
            tests_run++;
            if (d !== ctrl_exp) begin tests_failed++; $display("FAIL rand%0d_ctrl: got %02h expected %02h", it, d, ctrl_exp); end
            stop_and_clear();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = 3'd0; data_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_periodic();
        test_min_period();
        test_w1c_race();
        test_ctrl_race();
        test_atomic();
        test_held_strobe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
